// File: rtl/jericalla_fetch_if.sv
// ---------------------------------------------------------------------------
// jericalla_fetch_if
//
// Purpose: bundles the instruction-memory load bus and the issue bus that
// feeds the Jericalla core's `instruccion` input.
//
// Signals:
//   load_we     - instruction-memory write strobe (loader -> fetch)
//   load_addr   - write address, ADDR_W bits        (loader -> fetch)
//   load_data   - 18-bit instruction word to write  (loader -> fetch)
//   instruccion - registered instruction word       (fetch  -> core)
//   instr_valid - instruccion carries a real instruction this cycle
//
// Issue-bus semantics: there is no back-pressure. When instr_valid is 1 the
// core must consume instruccion in that cycle; when instr_valid is 0 the
// word is a bubble (NOP_WORD) and must be ignored.
//
// Modports:
//   slave  - the fetch unit (receives loads, drives the issue bus)
//   master - the loader/core side (drives loads, observes the issue bus)
// ---------------------------------------------------------------------------
interface jericalla_fetch_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [17:0]       load_data;
    logic [17:0]       instruccion;
    logic              instr_valid;

    modport slave (
        input  load_we,
        input  load_addr,
        input  load_data,
        output instruccion,
        output instr_valid
    );

    modport master (
        output load_we,
        output load_addr,
        output load_data,
        input  instruccion,
        input  instr_valid
    );
endinterface

// File: rtl/jericalla_fetch.sv
// ---------------------------------------------------------------------------
// jericalla_fetch
//
// Purpose: instruction-fetch front end of the Jericalla pipeline. Holds a
// writable instruction memory and a program counter, and issues one
// registered 18-bit instruction per cycle until a HALT opcode is fetched or
// the last memory word has been issued.
//
// Ports:
//   clk        - pipeline clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle pulse: begin execution from address 0
//   bus        - jericalla_fetch_if.slave: load_we/load_addr/load_data in,
//                instruccion/instr_valid out
//   pc         - address of the next word to fetch
//   halted     - fetch has stopped (HALT seen or end of memory)
//   busy       - FSM is in RUN
//   dbg_state  - raw FSM state (0 IDLE, 1 RUN, 2 HALT) for observation
//
// Optional feature (macro JERICALLA_FETCH_HAZARD_EN): when defined, fetch
// tracks the destination register and write status of the last two issued
// instructions and inserts bubbles until a read-after-write dependency has
// left that two-slot window. When undefined, issue is always back-to-back.
// ---------------------------------------------------------------------------
module jericalla_fetch #(
    parameter int unsigned ADDR_W     = 6,
    parameter logic [17:0] NOP_WORD   = 18'h00000,
    parameter logic [2:0]  HALT_OP    = 3'b111,
    parameter logic [7:0]  WR_OP_MASK = 8'b0111_1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    jericalla_fetch_if.slave  bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [17:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    // Set after the last memory word has been issued; the following RUN
    // cycle is a drain cycle that emits a bubble and enters HALT.
    logic              last_q, last_d;

    logic              mem_we;
    logic [17:0]       mem_q [DEPTH];
    logic [17:0]       fetch_word;
    logic [2:0]        fetch_op;
    logic              stall;

    // Asynchronous read; the output register supplies the one cycle of latency.
    assign fetch_word = mem_q[pc_q];
    assign fetch_op   = fetch_word[17:15];

    // Memory is deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        halted_d = halted_q;
        last_d   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Loads are accepted only while fetch is stopped.
                mem_we = bus.load_we;
                if (start) begin
                    state_d  = ST_RUN;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (last_q) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (fetch_op == HALT_OP) begin
                    // The HALT word itself is never issued and pc stays on it.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (stall) begin
                    // Bubble: pc holds so the dependent word is retried.
                    pc_d = pc_q;
                end else begin
                    instr_d = fetch_word;
                    valid_d = 1'b1;
                    if (pc_q == LAST_ADDR) begin
                        last_d = 1'b1;          // no wrap-around
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            last_q   <= last_d;
        end
    end

`ifdef JERICALLA_FETCH_HAZARD_EN
    // Two-slot window: slot 0 is the most recent issue cycle, slot 1 the one
    // before. Bubbles enter the window as non-writers, so a writer leaves
    // after two cycles regardless of what follows it.
    logic [4:0] wa0_q, wa0_d, wa1_q, wa1_d;
    logic       wr0_q, wr0_d, wr1_q, wr1_d;
    logic [4:0] ra1, ra2;

    assign ra1   = fetch_word[9:5];
    assign ra2   = fetch_word[4:0];
    assign stall = (wr0_q && ((ra1 == wa0_q) || (ra2 == wa0_q))) ||
                   (wr1_q && ((ra1 == wa1_q) || (ra2 == wa1_q)));

    always_comb begin
        wa0_d = '0;
        wr0_d = 1'b0;
        wa1_d = '0;
        wr1_d = 1'b0;
        if (state_q == ST_RUN) begin
            wa1_d = wa0_q;
            wr1_d = wr0_q;
            wa0_d = fetch_word[14:10];
            wr0_d = valid_d & WR_OP_MASK[fetch_op];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa0_q <= '0;
            wr0_q <= 1'b0;
            wa1_q <= '0;
            wr1_q <= 1'b0;
        end else begin
            wa0_q <= wa0_d;
            wr0_q <= wr0_d;
            wa1_q <= wa1_d;
            wr1_q <= wr1_d;
        end
    end
`else
    assign stall = 1'b0;
    logic unused_wr_mask;
    assign unused_wr_mask = ^WR_OP_MASK;
`endif

    assign bus.instruccion = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;
    assign busy            = (state_q == ST_RUN);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_jericalla_fetch.sv
// ---------------------------------------------------------------------------
// tb_jericalla_fetch
//
// Bench for jericalla_fetch. A behavioural model keeps its own copy of the
// instruction memory; on every accepted start it walks that memory and
// expands the whole expected issue stream (words, bubbles, final halt cycle)
// into a queue, which is then popped one entry per clock. A compare process
// checks every DUT output on each falling edge against the current entry.
// Directed literal checks pin the expected values for the documented cases.
// ---------------------------------------------------------------------------
module tb_jericalla_fetch;

    localparam int          ADDR_W     = 6;
    localparam int          DEPTH      = 64;
    localparam logic [17:0] NOP_WORD   = 18'h00000;
    localparam logic [2:0]  HALT_OP    = 3'b111;
    localparam logic [7:0]  WR_OP_MASK = 8'b0111_1111;

    typedef struct packed {
        logic              valid;
        logic [17:0]       instr;
        logic [ADDR_W-1:0] pc;
        logic              halted;
        logic              busy;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              busy;
    logic [1:0]        dbg_state;

    jericalla_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    jericalla_fetch #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .pc        (pc),
        .halted    (halted),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec   = 0;
    int          n_fail  = 0;
    int          n_valid = 0;
    bit          checking = 1'b0;
    logic [17:0] m_mem [DEPTH];
    exp_t        exp_q[$];
    exp_t        cur;
    bit          m_running;

    function automatic exp_t mk(input logic v, input logic [17:0] ins,
                                input logic [ADDR_W-1:0] p, input logic h,
                                input logic b);
        mk = {v, ins, p, h, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expand the program in m_mem into the per-cycle output stream that
    // follows the start edge.
    function automatic void build_expected();
        logic [17:0] w;
        logic [4:0]  win_wa [2];
        logic        win_wr [2];
        bit          dep;
        win_wa[0] = '0; win_wa[1] = '0;
        win_wr[0] = 1'b0; win_wr[1] = 1'b0;
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            w = m_mem[a];
            if (w[17:15] == HALT_OP) begin
                exp_q.push_back(mk(1'b0, NOP_WORD, ADDR_W'(a), 1'b1, 1'b0));
                return;
            end
`ifdef JERICALLA_FETCH_HAZARD_EN
            dep = 1'b1;
            while (dep) begin
                dep = 1'b0;
                for (int s = 0; s < 2; s++)
                    if (win_wr[s] && (w[9:5] == win_wa[s] || w[4:0] == win_wa[s]))
                        dep = 1'b1;
                if (dep) begin
                    exp_q.push_back(mk(1'b0, NOP_WORD, ADDR_W'(a), 1'b0, 1'b1));
                    win_wa[1] = win_wa[0]; win_wr[1] = win_wr[0];
                    win_wa[0] = '0;        win_wr[0] = 1'b0;
                end
            end
            win_wa[1] = win_wa[0]; win_wr[1] = win_wr[0];
            win_wa[0] = w[14:10];  win_wr[0] = WR_OP_MASK[w[17:15]];
`else
            dep = 1'b0;
            win_wa[0] = w[14:10];
            win_wr[0] = dep;
`endif
            if (a == DEPTH - 1) begin
                exp_q.push_back(mk(1'b1, w, ADDR_W'(a), 1'b0, 1'b1));
                exp_q.push_back(mk(1'b0, NOP_WORD, ADDR_W'(a), 1'b1, 1'b0));
                return;
            end
            exp_q.push_back(mk(1'b1, w, ADDR_W'(a + 1), 1'b0, 1'b1));
        end
    endfunction

    // Reference model: advances on every rising edge, resets asynchronously.
    initial begin
        cur       = mk(1'b0, NOP_WORD, '0, 1'b0, 1'b0);
        m_running = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
                m_running = 1'b0;
                cur = mk(1'b0, NOP_WORD, '0, 1'b0, 1'b0);
            end else if (m_running) begin
                cur = exp_q.pop_front();
                if (exp_q.size() == 0) m_running = 1'b0;
            end else begin
                if (bus.load_we) m_mem[bus.load_addr] = bus.load_data;
                if (start) begin
                    build_expected();
                    cur = mk(1'b0, NOP_WORD, '0, 1'b0, 1'b1);
                    m_running = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (checking && !rst) begin
            check("instruccion", 32'(bus.instruccion), 32'(cur.instr));
            check("instr_valid", 32'(bus.instr_valid), 32'(cur.valid));
            check("pc",          32'(pc),              32'(cur.pc));
            check("halted",      32'(halted),          32'(cur.halted));
            check("busy",        32'(busy),            32'(cur.busy));
            if (bus.instr_valid === 1'b1) n_valid++;
        end
    end

    // ---------------- driver tasks (called on a falling edge) ----------------
    task automatic load_word(input int a, input logic [17:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = ADDR_W'(a);
        bus.load_data = d;
        @(negedge clk);
        bus.load_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (halted === 1'b1) break;
            @(negedge clk);
        end
        if (halted !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_halted: halted=%b after %0d cycles, expected 1", halted, max_cycles);
        end
    endtask

    task automatic reset_mid_cycle();
        #2 rst = 1'b1;
        #1;
        check("rst_instr",  32'(bus.instruccion), 32'(NOP_WORD));
        check("rst_valid",  32'(bus.instr_valid), 32'd0);
        check("rst_pc",     32'(pc),              32'd0);
        check("rst_halted", 32'(halted),          32'd0);
        check("rst_busy",   32'(busy),            32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [17:0] rand_word();
        logic [17:0] w;
        w        = 18'($urandom);
        w[17:15] = 3'($urandom_range(0, 6));
        w[14:10] = 5'($urandom_range(0, 3));
        w[9:5]   = 5'($urandom_range(0, 3));
        w[4:0]   = 5'($urandom_range(0, 7));
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [17:0] orig5;
        logic [17:0] w;
        int          len;
        int          n_run;

        rst = 1'b1;
        start = 1'b0;
        bus.load_we = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        repeat (3) @(negedge clk);
        check("por_instr",  32'(bus.instruccion), 32'(NOP_WORD));
        check("por_valid",  32'(bus.instr_valid), 32'd0);
        check("por_pc",     32'(pc),              32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        checking = 1'b1;

        for (int a = 0; a < DEPTH; a++) load_word(a, 18'h00421);

        // Idle with start held low.
        repeat (10) @(negedge clk);
        check("idle_pc",     32'(pc),              32'd0);
        check("idle_valid",  32'(bus.instr_valid), 32'd0);
        check("idle_halted", 32'(halted),          32'd0);
        check("idle_busy",   32'(busy),            32'd0);

        // Sequential fetch, then restart from HALT with an identical sequence.
        load_word(0, 18'h01021);
        load_word(1, 18'h02043);
        load_word(2, 18'h38000);
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            check("seq_busy",   32'(busy),   32'd1);
            check("seq_halted", 32'(halted), 32'd0);
            @(negedge clk);
            check("seq_w0",     32'(bus.instruccion), 32'h01021);
            check("seq_v0",     32'(bus.instr_valid), 32'd1);
            @(negedge clk);
            check("seq_w1",     32'(bus.instruccion), 32'h02043);
            @(negedge clk);
            check("seq_halt_instr", 32'(bus.instruccion), 32'(NOP_WORD));
            check("seq_halt_valid", 32'(bus.instr_valid), 32'd0);
            check("seq_halt_flag",  32'(halted),          32'd1);
            check("seq_halt_pc",    32'(pc),              32'd2);
        end

        // Reset in the middle of RUN drops the in-flight word.
        pulse_start();
        @(negedge clk);
        reset_mid_cycle();
        repeat (2) @(negedge clk);

        // Dependency case: word1 reads the register word0 writes.
        load_word(0, 18'h00C00);
        load_word(1, 18'h08060);
        load_word(2, 18'h38000);
        pulse_start();
        @(negedge clk);
        check("haz_w0", 32'(bus.instruccion), 32'h00C00);
`ifdef JERICALLA_FETCH_HAZARD_EN
        @(negedge clk);
        check("haz_bubble0", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("haz_bubble1", 32'(bus.instr_valid), 32'd0);
`endif
        @(negedge clk);
        check("haz_w1", 32'(bus.instruccion), 32'h08060);
        check("haz_v1", 32'(bus.instr_valid), 32'd1);
        wait_halted(20);

        // End of memory: every word issued once, no wrap.
        for (int a = 0; a < DEPTH; a++) load_word(a, 18'h00421);
        n_valid = 0;
        pulse_start();
        wait_halted(300);
        @(negedge clk);
        check("eom_issues", 32'(n_valid), 32'd64);
        check("eom_pc",     32'(pc),      32'd63);
        check("eom_halted", 32'(halted),  32'd1);
        repeat (3) @(negedge clk);
        check("eom_nowrap_pc", 32'(pc), 32'd63);

        // start and load in the same cycle: the write lands before fetch.
        bus.load_we = 1'b1;
        bus.load_addr = '0;
        bus.load_data = 18'h0A5A5;
        start = 1'b1;
        @(negedge clk);
        bus.load_we = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("startload_w0", 32'(bus.instruccion), 32'h0A5A5);
        wait_halted(300);

        // Load lockout during RUN.
        for (int a = 0; a < 16; a++) begin
            w = rand_word();
            if (a == 5) orig5 = w;
            load_word(a, w);
        end
        load_word(16, 18'h38000);
        pulse_start();
        repeat (2) @(negedge clk);
        load_word(5, 18'h3FFFF);
        wait_halted(200);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1 && pc === 6'd6) begin
                check("lockout_w5", 32'(bus.instruccion), 32'(orig5));
                break;
            end
        end
        wait_halted(200);

        // Randomized programs with random start/load noise during RUN.
        for (int it = 0; it < 24; it++) begin
            len = $urandom_range(1, 70);
            for (int a = 0; a < DEPTH && a <= len; a++) begin
                w = rand_word();
                if (a == len) w[17:15] = HALT_OP;
                load_word(a, w);
            end
            pulse_start();
            n_run = $urandom_range(0, 40);
            for (int k = 0; k < n_run; k++) begin
                start         = ($urandom_range(0, 7) == 0);
                bus.load_we   = ($urandom_range(0, 3) == 0);
                bus.load_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                bus.load_data = ($urandom_range(0, 5) == 0) ? 18'($urandom) : rand_word();
                @(negedge clk);
            end
            start = 1'b0;
            bus.load_we = 1'b0;
            if (it % 6 == 5) reset_mid_cycle();
            else wait_halted(400);
        end

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/jericalla_fetch.md
Name: jericalla_fetch

Overview:
- Instruction-fetch front end of the Jericalla pipeline.
- Holds a writable instruction memory and a program counter.
- Drives a registered 18-bit instruction word into the core's `instruccion` input, one instruction per cycle.
- Stops at a HALT opcode or at the end of memory.

Parameters:
- ADDR_W, 6, instruction-memory address width; depth = 2**ADDR_W words.
- NOP_WORD, 18'h00000, word driven when no valid instruction is issued (bubble).
- HALT_OP, 3'b111, opcode (bits 17:15) that stops fetch.
- WR_OP_MASK, 8'b0111_1111, bit i set means opcode i writes the register bank (used only by the optional feature).

Ports:
- clk, input, 1, pipeline clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse that begins execution from address 0.
- load_we, input, 1, instruction-memory write strobe.
- load_addr, input, ADDR_W, instruction-memory write address.
- load_data, input, 18, instruction word to write.
- instruccion, output, 18, registered instruction to the core. Fields: op[17:15], WA[14:10], RA1[9:5], RA2[4:0].
- instr_valid, output, 1, instruccion holds a real instruction this cycle.
- pc, output, ADDR_W, address of the next word to fetch.
- halted, output, 1, fetch has stopped (HALT seen or end of memory).
- busy, output, 1, state is RUN.

Behaviour:
- Reset (async, on assertion):
  - state=IDLE, pc=0, instruccion=NOP_WORD, instr_valid=0, halted=0, busy=0.
  - Memory contents are not cleared.
- Memory:
  - Synchronous write when load_we=1 and state is IDLE or HALT.
  - load_we in RUN is ignored; no write occurs.
  - Read is asynchronous at address pc; the output register provides the single cycle of latency.
- States:
  - IDLE: instruccion=NOP_WORD, instr_valid=0. start=1 → RUN, pc=0.
  - RUN: each cycle, instruccion<=mem[pc], instr_valid<=1, pc<=pc+1.
    - Fetched op==HALT_OP: the HALT word is not issued (instruccion<=NOP_WORD, instr_valid<=0), pc holds, → HALT.
    - pc==2**ADDR_W-1: that word is issued normally, pc holds, → HALT next cycle. No wrap-around.
  - HALT: halted=1, instruccion=NOP_WORD, instr_valid=0. start=1 → RUN, pc=0, halted=0.
- Latency: first instruction appears on instruccion in the cycle after the start edge.
- start while in RUN: ignored.
- start and load_we in the same cycle (IDLE/HALT): the write completes and the state goes to RUN. The word fetched from address 0 in the following cycle reflects the write if load_addr==0.
- rst in mid-RUN: immediate return to the reset values. The in-flight word is dropped.
- pc output equals the internal fetch pointer.

Optional Feature:
- Macro: JERICALLA_FETCH_HAZARD_EN.
- Defined:
  - Fetch tracks the WA field and writing status (WR_OP_MASK[op]) of the last two issued instructions.
  - If mem[pc] has RA1 or RA2 equal to a tracked WA whose writer is still in flight, fetch inserts a bubble: instruccion=NOP_WORD, instr_valid=0, pc holds.
  - This repeats until the writer has left the window, so the core's 2-stage buffer pipeline reaches register writeback before the dependent read.
  - Bubbles age the tracking window like issued instructions.
  - A HALT word is never stalled.
- Undefined: no dependency check. Back-to-back issue always occurs and software must pad with NOPs.

Test Plan:
- Reset/idle: assert rst mid-cycle → outputs immediately NOP_WORD, instr_valid=0, pc=0, halted=0. Hold start=0 for 10 cycles → no change.
- Sequential fetch: load words 0x01021, 0x02043, 0x38000 (HALT) at addresses 0..2, pulse start → cycle+1 0x01021 valid, cycle+2 0x02043 valid, cycle+3 NOP/invalid, halted=1, pc=2.
- End of memory: fill all 64 words with 0x00421, start → 64 valid issues, then halted=1, pc=63, no wrap to 0.
- Load lockout: in RUN, drive load_we=1 at address 5 with 0x3FFFF → after halt, read path (restart) shows the original word at address 5.
- Restart from HALT: pulse start in HALT → halted drops next cycle, refetch from address 0 with an identical sequence.
- Hazard (macro defined): word0 with WA=3, word1 with RA1=3 → word0 valid, two bubble cycles, then word1 valid. With macro undefined → word1 issues in the cycle after word0.
